cntr_hex_display: RTL and testbench

- Downstream consumer of the counter block's 20-bit count output.
- Takes one snapshot of the count per scan frame and time-multiplexes it as hex digits onto a common 7-segment bus plus per-digit enables.
- Its outputs drive user GPIO pads in the wrapper, including output-enable control.

---
 rtl/cntr_hex_display.sv | 113 +++++++++++
 tb/tb_cntr_hex_display.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cntr_hex_display.sv
// Hex scan driver for the counter value.
// Snapshots the count once per frame and multiplexes it onto 7-seg pads.
module cntr_hex_display #(
  parameter int NUM_DIGITS = 5,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [4*NUM_DIGITS-1:0] cnt_i,
  input  logic                    blank_en_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_o,
  output logic [6+NUM_DIGITS:0]   oeb_o
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLNK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF =
    (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE =
    NUM_DIGITS'(1);

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_snap;

  logic                  w_tick;
  logic                  w_last;
  logic [CW-1:0]         w_upper;
  logic [3:0]            w_nib;
  logic                  w_lz;
  logic                  w_off;
  logic [6:0]            w_font;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_dig;

  assign w_tick  = (r_pre == P_LAST);
  assign w_last  = (r_idx == I_LAST);
  assign w_upper = r_snap >> {r_idx, 2'b00};
  assign w_nib   = w_upper[3:0];
  assign w_lz    = blank_en_i && (r_idx != '0)
                && (w_upper == '0);
  assign w_off   = (r_pre < P_BLNK) || w_lz;

  // Hex font lookup, segments ordered {g,f,e,d,c,b,a}
  always_comb begin
    w_font = 7'h00;
    case (w_nib)
      4'h0: w_font = 7'h3F;
      4'h1: w_font = 7'h06;
      4'h2: w_font = 7'h5B;
      4'h3: w_font = 7'h4F;
      4'h4: w_font = 7'h66;
      4'h5: w_font = 7'h6D;
      4'h6: w_font = 7'h7D;
      4'h7: w_font = 7'h07;
      4'h8: w_font = 7'h7F;
      4'h9: w_font = 7'h6F;
      4'hA: w_font = 7'h77;
      4'hB: w_font = 7'h7C;
      4'hC: w_font = 7'h39;
      4'hD: w_font = 7'h5E;
      4'hE: w_font = 7'h79;
      4'hF: w_font = 7'h71;
      default: w_font = 7'h00;
    endcase
  end

  // Active-high view of the current slot before polarity
  always_comb begin
    w_seg = 7'h00;
    w_dig = '0;
    if (!w_off) begin
      w_seg = w_font;
      w_dig = DIG_ONE << r_idx;
    end
  end

  // Scan state, frame snapshot and registered pad outputs
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      frame_o <= 1'b0;
      seg_o   <= SEG_OFF;
      dig_o   <= DIG_OFF;
      oeb_o   <= '1;
    end else begin
      r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      frame_o <= w_tick && w_last;
      if (w_tick)
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      if (w_tick && w_last)
        r_snap <= cnt_i;
      seg_o   <= w_seg ^ SEG_OFF;
      dig_o   <= w_dig ^ DIG_OFF;
      oeb_o   <= '0;
    end
  end

endmodule

// File: tb/tb_cntr_hex_display.sv
// Bench for cntr_hex_display: both polarities against a frame-level model.
// Random count/blank/reset activity plus the directed scan scenarios.
module tb_cntr_hex_display;

  localparam int ND = 5;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [19:0]   cnt = 20'h12345;
  logic          blank = 1'b0;

  logic [6:0]    seg_a, seg_b;
  logic [4:0]    dig_a, dig_b;
  logic          frame_a, frame_b;
  logic [11:0]   oeb_a, oeb_b;

  always #5 clk = ~clk;

  cntr_hex_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD),
    .BLANK_CYC(BC), .ACTIVE_LOW(1)
  ) u_lo (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cnt_i(cnt), .blank_en_i(blank),
    .seg_o(seg_a), .dig_o(dig_a),
    .frame_o(frame_a), .oeb_o(oeb_a)
  );

  cntr_hex_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD),
    .BLANK_CYC(BC), .ACTIVE_LOW(0)
  ) u_hi (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cnt_i(cnt), .blank_en_i(blank),
    .seg_o(seg_b), .dig_o(dig_b),
    .frame_o(frame_b), .oeb_o(oeb_b)
  );

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          n_cmp = 0;
  int          n_bad = 0;
  int          t_run = 0;
  logic [19:0] m_snap = '0;
  int          rel_cnt = 0;
  int          first_fr = -1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // One clock: predict from the displayed frame, then sample.
  task automatic step();
    logic [6:0]  es;
    logic [4:0]  ed;
    logic        ef;
    logic        eo;
    logic [19:0] up;
    int          p, i;
    es = '0; ed = '0; ef = 1'b0; eo = 1'b1;
    if (!rst_n) begin
      t_run  = 0;
      m_snap = '0;
    end else begin
      p  = t_run % SD;
      i  = t_run / SD;
      up = m_snap >> (4 * i);
      eo = 1'b0;
      if (!(p < BC) && !(blank && i > 0 && up == 0)) begin
        es = font[up[3:0]];
        ed = 5'(1 << i);
      end
      ef = (t_run == FR - 1);
      if (ef) m_snap = cnt;
      t_run = (t_run + 1) % FR;
    end
    @(posedge clk);
    @(negedge clk);
    chk("seg_lo", 32'(seg_a), 32'(es ^ 7'h7F));
    chk("dig_lo", 32'(dig_a), 32'(ed ^ 5'h1F));
    chk("frm_lo", 32'(frame_a), 32'(ef));
    chk("oeb_lo", 32'(oeb_a), eo ? 32'hFFF : 32'h0);
    chk("seg_hi", 32'(seg_b), 32'(es));
    chk("dig_hi", 32'(dig_b), 32'(ed));
    chk("frm_hi", 32'(frame_b), 32'(ef));
    chk("oeb_hi", 32'(oeb_b), eo ? 32'hFFF : 32'h0);
    if (rst_n) rel_cnt++;
    else rel_cnt = 0;
    if (frame_a && first_fr < 0) first_fr = rel_cnt;
  endtask

  task automatic run(input int k);
    for (int c = 0; c < k; c++) step();
  endtask

  initial begin
    rst_n = 1'b0; cnt = 20'h12345; blank = 1'b0;
    run(3);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_dig", 32'(dig_a), 32'h1F);
    chk("rst_oeb", 32'(oeb_a), 32'hFFF);

    rst_n = 1'b1;
    run(1);
    chk("rel_oeb", 32'(oeb_a), 32'h0);
    run(1);
    chk("d0_snap0", 32'(seg_a), 32'h40);
    run(2 * FR - 2);
    chk("first_frame", 32'(first_fr), 32'd20);

    run(2 * SD + 2);
    cnt = 20'hFFFFF;
    run(FR - 2 * SD - 2 + FR);

    cnt = 20'h00A07; blank = 1'b1;
    run(2 * FR);
    cnt = 20'h00000;
    run(2 * FR);
    blank = 1'b0;
    run(FR);

    cnt = 20'h00008; blank = 1'b1;
    run(2 * FR);

    cnt = 20'h54321;
    run(FR + 3 * SD + 2);
    rst_n = 1'b0;
    run(1);
    chk("mid_oeb", 32'(oeb_a), 32'hFFF);
    rst_n = 1'b1;
    run(FR + 2);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 29) == 0) cnt = 20'($urandom);
      if ($urandom_range(0, 4) == 0)
        cnt = 20'($urandom_range(0, 255));
      if ($urandom_range(0, 40) == 0) blank = ~blank;
      rst_n = ($urandom_range(0, 150) != 0);
      step();
    end
    rst_n = 1'b1;
    run(FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
